regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (WE3/AD3/WD3) among NREQ writeback requesters (ALU, load, mul/div).
//  Arbitration is round-robin; the winner is registered into a one-entry write stage that drives the port.
//  A 32-entry busy scoreboard tracks registers with outstanding writes so issue logic can stall RAW/WAW hazards.
// PARAMETERS
//  NREQ   3   number of writeback requesters (2..8)
//  XLEN   32  data width (from rf_ctrl_pkg)
// PORTS
//  clk          in   1          clock
//  rst          in   1          reset, asynchronous, active-high
//  req_valid    in   NREQ       requester i has a writeback
//  req_ready    out  NREQ       requester i accepted this cycle (one-hot or zero)
//  req_rd       in   NREQx5     destination register per requester
//  req_data     in   NREQxXLEN  writeback data per requester
//  issue_valid  in   1          issue stage wants to mark issue_rd busy
//  issue_rd     in   5          destination of issuing instruction
//  issue_ready  out  1          issue may proceed (no WAW on issue_rd)
//  busy_vec     out  32         scoreboard; bit r = write to xr outstanding
//  rf_we        out  1          to register file WE3
//  rf_ad        out  5          to register file AD3
//  rf_wd        out  XLEN       to register file WD3
// BEHAVIOUR
//  Reset (async, any cycle): rf_we=0, rf_ad=0, rf_wd=0, busy_vec=0, RR pointer=0; accepted-but-unwritten data is dropped.
//  Handshake: transfer on req_valid[i] & req_ready[i]; req_ready depends on req_valid (combinational grant); at most one grant/cycle.
//  Arbitration: search starts at pointer p, ascending with wrap; winner i -> p <= (i+1) mod NREQ; no grant -> p holds.
//  Write stage always accepts (write port is single-cycle); grant at cycle t -> rf_we=1, rf_ad/rf_wd valid in t+1 only.
//  No grant at t -> rf_we=0 at t+1; rf_ad/rf_wd hold previous values.
//  rd==0 request: handshake completes, rf_we stays 0 at t+1, busy_vec untouched (x0 never busy).
//  Scoreboard set: issue_valid & issue_ready & issue_rd!=0 -> busy[issue_rd]<=1.
//  Scoreboard clear: busy[rf_ad]<=0 at the edge ending a cycle with rf_we=1 (same edge the register file writes).
//  Set and clear of the same register on the same edge: set wins.
//  issue_ready = !(issue_rd!=0 & busy[issue_rd]); issue_rd==0 always ready.
//  Requests for registers not marked busy are legal and written normally (no check).
// CONFIGURATION
//  RFWB_FWD_EN defined: adds outputs fwd_valid(1)=rf_we, fwd_rd(5)=rf_ad, fwd_data(XLEN)=rf_wd for decode bypass,
//    and busy_vec excludes rf_ad while rf_we=1 (data available through forwarding).
//  RFWB_FWD_EN undefined: no fwd_* ports; busy_vec is the raw scoreboard.
// STRUCTURE
//  rf_ctrl_pkg: XLEN, REG_AW=5, NREG=32, typedef struct {rd, data} wb_req_t.
//  Sub-module rr_arbiter #(N): req vector in, one-hot grant out, internal pointer update on grant.
//  Top: rr_arbiter, grant mux, write-stage register, busy-vector register.
// TESTING
//  1 Reset: assert rst mid-run with rf_we=1 -> rf_we=0, busy_vec=0 immediately, no write after release.
//  2 Single: req_valid=3'b001, rd=5, data=0xDEADBEEF at t -> req_ready=001 at t; rf_we=1, ad=5, wd=DEADBEEF at t+1.
//  3 Round-robin: all 3 valid continuously for 6 cycles -> grants 0,1,2,0,1,2; rf_we high cycles 2..7.
//  4 rd=0: req rd=0 -> ready=1, rf_we=0 next cycle, busy_vec unchanged.
//  5 Scoreboard: issue rd=7 -> busy[7]=1; issue rd=7 again -> issue_ready=0; writeback rd=7 -> busy[7]=0 after rf_we edge.
//  6 Same-edge set/clear on x9 -> busy[9]=1 afterwards; with RFWB_FWD_EN, fwd_* mirror rf_* and busy_vec masks rf_ad.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// ============================================================================
//  Package    : rf_ctrl_pkg
//  Description: Shared widths and the writeback request record for the
//               register-file writeback arbiter.
//  Revision   : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package rf_ctrl_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
//  Interface  : regfile_wb_arbiter_if
//  Description: Requester, issue and register-file write-port signals.
//               Optional RFWB_FWD_EN adds the decode bypass outputs.
//  Revision   : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3
);
    import rf_ctrl_pkg::*;

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][REG_AW-1:0] req_rd;
    logic [NREQ-1:0][XLEN-1:0]   req_data;
    logic                        issue_valid;
    logic [REG_AW-1:0]           issue_rd;
    logic                        issue_ready;
    logic [NREG-1:0]             busy_vec;
    logic                        rf_we;
    logic [REG_AW-1:0]           rf_ad;
    logic [XLEN-1:0]             rf_wd;
`ifdef RFWB_FWD_EN
    logic                        fwd_valid;
    logic [REG_AW-1:0]           fwd_rd;
    logic [XLEN-1:0]             fwd_data;

    modport master (
        output req_valid, req_rd, req_data, issue_valid, issue_rd,
        input  req_ready, issue_ready, busy_vec, rf_we, rf_ad, rf_wd,
        input  fwd_valid, fwd_rd, fwd_data
    );
    modport slave (
        input  req_valid, req_rd, req_data, issue_valid, issue_rd,
        output req_ready, issue_ready, busy_vec, rf_we, rf_ad, rf_wd,
        output fwd_valid, fwd_rd, fwd_data
    );
`else
    modport master (
        output req_valid, req_rd, req_data, issue_valid, issue_rd,
        input  req_ready, issue_ready, busy_vec, rf_we, rf_ad, rf_wd
    );
    modport slave (
        input  req_valid, req_rd, req_data, issue_valid, issue_rd,
        output req_ready, issue_ready, busy_vec, rf_we, rf_ad, rf_wd
    );
`endif
endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module     : rr_arbiter
//  Description: Round-robin arbiter, one-hot grant, pointer moves past winner.
//  Revision   : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Scan offsets 0..N-1 from the pointer, wrapping modulo N.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
//  Module     : regfile_wb_arbiter
//  Description: Round-robin share of the register-file write port with a
//               busy scoreboard. Option macro: RFWB_FWD_EN (bypass outputs).
//  Revision   : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module regfile_wb_arbiter #(
    parameter int NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    import rf_ctrl_pkg::*;

    logic [NREQ-1:0]   gnt;
    wb_req_t           win;
    logic              wr_now;
    logic              issue_ok;
    logic              rf_we_q;
    logic [REG_AW-1:0] rf_ad_q;
    logic [XLEN-1:0]   rf_wd_q;
    logic [NREG-1:0]   busy_q, busy_d;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (bus.req_valid),
        .gnt_o (gnt)
    );

    assign bus.req_ready = gnt;

    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win.rd   = bus.req_rd[i];
                win.data = bus.req_data[i];
            end
        end
    end

    // x0 writes are accepted but never reach the port.
    assign wr_now   = (|gnt) && (win.rd != '0);
    assign issue_ok = !((bus.issue_rd != '0) && busy_q[bus.issue_rd]);

    // Clear first so a same-edge set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_ad_q] = 1'b0;
        end
        if (bus.issue_valid && issue_ok && (bus.issue_rd != '0)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q <= 1'b0;
            rf_ad_q <= '0;
            rf_wd_q <= '0;
            busy_q  <= '0;
        end else begin
            rf_we_q <= wr_now;
            if (wr_now) begin
                rf_ad_q <= win.rd;
                rf_wd_q <= win.data;
            end
            busy_q <= busy_d;
        end
    end

    assign bus.issue_ready = issue_ok;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_ad       = rf_ad_q;
    assign bus.rf_wd       = rf_wd_q;

`ifdef RFWB_FWD_EN
    assign bus.fwd_valid = rf_we_q;
    assign bus.fwd_rd    = rf_ad_q;
    assign bus.fwd_data  = rf_wd_q;
    assign bus.busy_vec  = busy_q & ~(rf_we_q ? (NREG'(1) << rf_ad_q) : '0);
`else
    assign bus.busy_vec  = busy_q;
`endif
endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
//  Module     : tb_regfile_wb_arbiter
//  Description: Directed vector table, reset sequence and randomized run
//               against a reference model of the writeback arbiter.
//  Revision   : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;
    import rf_ctrl_pkg::*;

    localparam int NREQ = 3;
    localparam int NVEC = 19;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] eff_busy(input logic [31:0] raw, input logic we, input logic [4:0] ad);
`ifdef RFWB_FWD_EN
        eff_busy = we ? (raw & ~(32'd1 << ad)) : raw;
`else
        eff_busy = raw;
`endif
    endfunction

    task automatic check_outs(input string tag, input logic [2:0] e_rdy, input logic e_ir,
                              input logic e_we, input logic [4:0] e_ad, input logic [31:0] e_wd,
                              input logic [31:0] e_busy);
        chk({tag, ".req_ready"},   64'(bus.req_ready),   64'(e_rdy));
        chk({tag, ".issue_ready"}, 64'(bus.issue_ready), 64'(e_ir));
        chk({tag, ".rf_we"},       64'(bus.rf_we),       64'(e_we));
        chk({tag, ".rf_ad"},       64'(bus.rf_ad),       64'(e_ad));
        chk({tag, ".rf_wd"},       64'(bus.rf_wd),       64'(e_wd));
        chk({tag, ".busy_vec"},    64'(bus.busy_vec),    64'(eff_busy(e_busy, e_we, e_ad)));
`ifdef RFWB_FWD_EN
        chk({tag, ".fwd_valid"},   64'(bus.fwd_valid),   64'(e_we));
        chk({tag, ".fwd_rd"},      64'(bus.fwd_rd),      64'(e_ad));
        chk({tag, ".fwd_data"},    64'(bus.fwd_data),    64'(e_wd));
`endif
    endtask

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  rd0, rd1, rd2;
        logic [31:0] d;
        logic        iv;
        logic [4:0]  ird;
        logic [2:0]  e_rdy;
        logic        e_ir;
        logic        e_we;
        logic [4:0]  e_ad;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [31:0] d, input logic iv,
                         input logic [4:0] ird);
        bus.req_valid   = v;
        bus.req_rd[0]   = r0;
        bus.req_rd[1]   = r1;
        bus.req_rd[2]   = r2;
        bus.req_data[0] = d;
        bus.req_data[1] = d ^ 32'd1;
        bus.req_data[2] = d ^ 32'd2;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
    endtask

    // Reference model state
    int          m_ptr;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_ad;
    logic [31:0] m_wd;

    task automatic rnd_cycle();
        logic [2:0]  v;
        logic [4:0]  rd [NREQ];
        logic [31:0] d;
        logic        iv;
        logic [4:0]  ird;
        int          g;
        logic [2:0]  e_rdy;
        logic        e_ir;
        @(negedge clk);
        v   = 3'($urandom_range(0, 7));
        for (int i = 0; i < NREQ; i++) rd[i] = 5'($urandom_range(0, 7));
        d   = $urandom;
        iv  = 1'($urandom_range(0, 1));
        ird = 5'($urandom_range(0, 7));
        drive(v, rd[0], rd[1], rd[2], d, iv, ird);
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && v[idx]) g = idx;
        end
        e_rdy = (g >= 0) ? 3'(1 << g) : 3'd0;
        e_ir  = (ird == 5'd0) || !m_busy[ird];
        check_outs("rnd", e_rdy, e_ir, m_we, m_ad, m_wd, m_busy);
        if (m_we) m_busy[m_ad] = 1'b0;
        if (iv && e_ir && ird != 5'd0) m_busy[ird] = 1'b1;
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            m_we  = (rd[g] != 5'd0);
            if (m_we) begin
                m_ad = rd[g];
                m_wd = d ^ 32'(g);
            end
        end else begin
            m_we = 1'b0;
        end
    endtask

    initial begin
        //           v     rd0 rd1 rd2 d             iv ird  rdy    ir we ad  wd            busy
        tbl[0]  = '{3'b000, 0, 0, 0, 32'h0,        0, 0,  3'b000, 1, 0, 0, 32'h0,        32'h0};
        tbl[1]  = '{3'b111, 1, 2, 3, 32'h100,      0, 0,  3'b001, 1, 0, 0, 32'h0,        32'h0};
        tbl[2]  = '{3'b111, 1, 2, 3, 32'h100,      0, 0,  3'b010, 1, 1, 1, 32'h100,      32'h0};
        tbl[3]  = '{3'b111, 1, 2, 3, 32'h100,      0, 0,  3'b100, 1, 1, 2, 32'h101,      32'h0};
        tbl[4]  = '{3'b111, 1, 2, 3, 32'h100,      0, 0,  3'b001, 1, 1, 3, 32'h102,      32'h0};
        tbl[5]  = '{3'b111, 1, 2, 3, 32'h100,      0, 0,  3'b010, 1, 1, 1, 32'h100,      32'h0};
        tbl[6]  = '{3'b111, 1, 2, 3, 32'h100,      0, 0,  3'b100, 1, 1, 2, 32'h101,      32'h0};
        tbl[7]  = '{3'b000, 0, 0, 0, 32'h0,        0, 0,  3'b000, 1, 1, 3, 32'h102,      32'h0};
        tbl[8]  = '{3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0,  3'b001, 1, 0, 3, 32'h102,      32'h0};
        tbl[9]  = '{3'b010, 0, 0, 0, 32'h55,       0, 0,  3'b010, 1, 1, 5, 32'hDEADBEEF, 32'h0};
        tbl[10] = '{3'b000, 0, 0, 0, 32'h0,        0, 0,  3'b000, 1, 0, 5, 32'hDEADBEEF, 32'h0};
        tbl[11] = '{3'b000, 0, 0, 0, 32'h0,        1, 7,  3'b000, 1, 0, 5, 32'hDEADBEEF, 32'h0};
        tbl[12] = '{3'b000, 0, 0, 0, 32'h0,        1, 7,  3'b000, 0, 0, 5, 32'hDEADBEEF, 32'h80};
        tbl[13] = '{3'b100, 0, 0, 7, 32'h70,       0, 0,  3'b100, 1, 0, 5, 32'hDEADBEEF, 32'h80};
        tbl[14] = '{3'b000, 0, 0, 0, 32'h0,        0, 0,  3'b000, 1, 1, 7, 32'h72,       32'h80};
        tbl[15] = '{3'b000, 0, 0, 0, 32'h0,        0, 0,  3'b000, 1, 0, 7, 32'h72,       32'h0};
        tbl[16] = '{3'b001, 9, 0, 0, 32'h99,       0, 0,  3'b001, 1, 0, 7, 32'h72,       32'h0};
        tbl[17] = '{3'b000, 0, 0, 0, 32'h0,        1, 9,  3'b000, 1, 1, 9, 32'h99,       32'h0};
        tbl[18] = '{3'b000, 0, 0, 0, 32'h0,        0, 0,  3'b000, 1, 0, 9, 32'h99,       32'h200};

        rst = 1'b1;
        drive(3'b000, 0, 0, 0, 32'h0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rd0, tbl[i].rd1, tbl[i].rd2, tbl[i].d, tbl[i].iv, tbl[i].ird);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_ir, tbl[i].e_we,
                       tbl[i].e_ad, tbl[i].e_wd, tbl[i].e_busy);
        end

        // Asynchronous reset while a write is on the port
        @(negedge clk);
        drive(3'b010, 0, 4, 0, 32'h44, 1'b1, 5'd12);
        #1;
        chk("rst.pre_ready", 64'(bus.req_ready), 64'(3'b010));
        @(posedge clk);
        #1;
        chk("rst.pre_we", 64'(bus.rf_we), 64'd1);
        chk("rst.pre_ad", 64'(bus.rf_ad), 64'd4);
        #1;
        rst = 1'b1;
        #1;
        chk("rst.we",   64'(bus.rf_we),    64'd0);
        chk("rst.busy", 64'(bus.busy_vec), 64'd0);
        chk("rst.ad",   64'(bus.rf_ad),    64'd0);
        chk("rst.wd",   64'(bus.rf_wd),    64'd0);
        @(negedge clk);
        drive(3'b000, 0, 0, 0, 32'h0, 1'b0, 5'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.post_we",   64'(bus.rf_we),    64'd0);
        chk("rst.post_busy", 64'(bus.busy_vec), 64'd0);
        @(negedge clk);
        drive(3'b111, 1, 1, 1, 32'h0, 1'b0, 5'd0);
        #1;
        chk("rst.ptr", 64'(bus.req_ready), 64'(3'b001));
        #1;
        drive(3'b000, 0, 0, 0, 32'h0, 1'b0, 5'd0);

        m_ptr  = 0;
        m_busy = '0;
        m_we   = 1'b0;
        m_ad   = '0;
        m_wd   = '0;
        repeat (400) rnd_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
